// File: rtl/axi_master_bridge.sv
// axi_master_bridge: single-outstanding AXI4 master. It takes one flat
// request from the IF/MEM arbiter, runs it as a single-beat INCR burst on
// AR/R or AW/W/B, and returns a one-cycle tagged response. Write data and
// strobes are moved onto their byte lanes. Read data is right-justified.
module axi_master_bridge #(
    parameter int ID_W = 4
) (
    input  logic            clock,
    input  logic            reset,

    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_wr,
    input  logic [31:0]     req_addr,
    input  logic [1:0]      req_size,
    input  logic [63:0]     req_wdata,
    input  logic [ID_W-1:0] req_id,

    output logic            resp_valid,
    output logic [ID_W-1:0] resp_id,
    output logic [63:0]     resp_rdata,
    output logic            resp_err,

    output logic            aw_valid,
    input  logic            aw_ready,
    output logic [31:0]     aw_addr,
    output logic [ID_W-1:0] aw_id,
    output logic [7:0]      aw_len,
    output logic [2:0]      aw_size,
    output logic [1:0]      aw_burst,

    output logic            w_valid,
    input  logic            w_ready,
    output logic [63:0]     w_data,
    output logic [7:0]      w_strb,
    output logic            w_last,

    input  logic            b_valid,
    output logic            b_ready,
    input  logic [1:0]      b_resp,
    input  logic [ID_W-1:0] b_id,

    output logic            ar_valid,
    input  logic            ar_ready,
    output logic [31:0]     ar_addr,
    output logic [ID_W-1:0] ar_id,
    output logic [7:0]      ar_len,
    output logic [2:0]      ar_size,
    output logic [1:0]      ar_burst,

    input  logic            r_valid,
    output logic            r_ready,
    input  logic [63:0]     r_data,
    input  logic [1:0]      r_resp,
    input  logic            r_last,
    input  logic [ID_W-1:0] r_id
);

    typedef enum logic [2:0] {IDLE, MIS, AR, R, AW_W, B, RESP} state_t;

    state_t          state;
    state_t          state_next;

    logic [31:0]     addr_q;
    logic [1:0]      size_q;
    logic [ID_W-1:0] id_q;
    logic [63:0]     wdata_q;
    logic [7:0]      wstrb_q;
    logic [63:0]     rdata_q;
    logic            err_q;
    logic            aw_done;
    logic            w_done;

    // With only one transaction ever in flight, the returned IDs and RLAST
    // carry no information, so they are deliberately left unused.
    logic            unused_axi;
    assign unused_axi = ^{b_id, r_id, r_last};

    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
        logic bad;
        bad = 1'b0;
        case (size)
            2'b01:   bad = off[0];
            2'b10:   bad = |off[1:0];
            2'b11:   bad = |off;
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

    function automatic logic [7:0] strb_base(input logic [1:0] size);
        logic [7:0] s;
        s = 8'h01;
        case (size)
            2'b00:   s = 8'h01;
            2'b01:   s = 8'h03;
            2'b10:   s = 8'h0F;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    function automatic logic [63:0] size_mask(input logic [1:0] size);
        logic [63:0] m;
        m = 64'hFF;
        case (size)
            2'b00:   m = 64'h0000_0000_0000_00FF;
            2'b01:   m = 64'h0000_0000_0000_FFFF;
            2'b10:   m = 64'h0000_0000_FFFF_FFFF;
            default: m = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        return m;
    endfunction

    // State register; reset abandons any transaction and drops all valids.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request latch, lane alignment, handshake tracking and response capture.
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q  <= '0;
            size_q  <= '0;
            id_q    <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        size_q  <= req_size;
                        id_q    <= req_id;
                        wdata_q <= req_wdata << {req_addr[2:0], 3'b000};
                        wstrb_q <= strb_base(req_size) << req_addr[2:0];
                        rdata_q <= '0;
                        err_q   <= 1'b0;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                    end
                end
                MIS: begin
                    err_q <= 1'b1;
                end
                R: begin
                    if (r_valid) begin
                        rdata_q <= (r_data >> {addr_q[2:0], 3'b000}) & size_mask(size_q);
                        err_q   <= |r_resp;
                    end
                end
                AW_W: begin
                    if (aw_ready) begin
                        aw_done <= 1'b1;
                    end
                    if (w_ready) begin
                        w_done <= 1'b1;
                    end
                end
                B: begin
                    if (b_valid) begin
                        err_q <= |b_resp;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state selection and handshake outputs decoded from registered state.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        ar_valid   = 1'b0;
        r_ready    = 1'b0;
        aw_valid   = 1'b0;
        w_valid    = 1'b0;
        b_ready    = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (misaligned(req_size, req_addr[2:0])) begin
                        state_next = MIS;
                    end else if (req_wr) begin
                        state_next = AW_W;
                    end else begin
                        state_next = AR;
                    end
                end
            end
            MIS: begin
                state_next = RESP;
            end
            AR: begin
                ar_valid = 1'b1;
                if (ar_ready) begin
                    state_next = R;
                end
            end
            R: begin
                r_ready = 1'b1;
                if (r_valid) begin
                    state_next = RESP;
                end
            end
            AW_W: begin
                aw_valid = !aw_done;
                w_valid  = !w_done;
                if ((aw_done || aw_ready) && (w_done || w_ready)) begin
                    state_next = B;
                end
            end
            B: begin
                b_ready = 1'b1;
                if (b_valid) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign resp_id    = id_q;
    assign resp_rdata = rdata_q;

    assign ar_addr  = addr_q;
    assign ar_id    = id_q;
    assign ar_len   = 8'd0;
    assign ar_size  = {1'b0, size_q};
    assign ar_burst = 2'b01;

    assign aw_addr  = addr_q;
    assign aw_id    = id_q;
    assign aw_len   = 8'd0;
    assign aw_size  = {1'b0, size_q};
    assign aw_burst = 2'b01;

    assign w_data = wdata_q;
    assign w_strb = wstrb_q;
    assign w_last = 1'b1;

endmodule

// File: tb/tb_axi_master_bridge.sv
// tb_axi_master_bridge: drives directed and random requests into the bridge
// while acting as the AXI slave, and compares every cycle against a
// byte-level model of what the bridge should present and return.
module tb_axi_master_bridge;

    localparam int ID_W = 4;

    logic            clock;
    logic            reset;
    logic            req_valid;
    logic            req_ready;
    logic            req_wr;
    logic [31:0]     req_addr;
    logic [1:0]      req_size;
    logic [63:0]     req_wdata;
    logic [ID_W-1:0] req_id;
    logic            resp_valid;
    logic [ID_W-1:0] resp_id;
    logic [63:0]     resp_rdata;
    logic            resp_err;
    logic            aw_valid;
    logic            aw_ready;
    logic [31:0]     aw_addr;
    logic [ID_W-1:0] aw_id;
    logic [7:0]      aw_len;
    logic [2:0]      aw_size;
    logic [1:0]      aw_burst;
    logic            w_valid;
    logic            w_ready;
    logic [63:0]     w_data;
    logic [7:0]      w_strb;
    logic            w_last;
    logic            b_valid;
    logic            b_ready;
    logic [1:0]      b_resp;
    logic [ID_W-1:0] b_id;
    logic            ar_valid;
    logic            ar_ready;
    logic [31:0]     ar_addr;
    logic [ID_W-1:0] ar_id;
    logic [7:0]      ar_len;
    logic [2:0]      ar_size;
    logic [1:0]      ar_burst;
    logic            r_valid;
    logic            r_ready;
    logic [63:0]     r_data;
    logic [1:0]      r_resp;
    logic            r_last;
    logic [ID_W-1:0] r_id;

    int checkCount = 0;
    int passCount  = 0;

    axi_master_bridge #(.ID_W(ID_W)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata), .req_id(req_id),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_id(aw_id),
        .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
        .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp), .b_id(b_id),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_id(ar_id),
        .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
        .r_last(r_last), .r_id(r_id)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                                 input logic [63:0] wdata, input logic [ID_W-1:0] id);
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_size  = size;
        req_wdata = wdata;
        req_id    = id;
        checkOutput("req_ready_idle", {63'd0, req_ready}, 64'd1);
        nextCycle();
        req_valid = 1'b0;
        req_wr    = 1'($urandom);
        req_addr  = $urandom;
        req_size  = 2'($urandom);
        req_wdata = {$urandom, $urandom};
        req_id    = ID_W'($urandom);
    endtask

    task automatic checkResponse(input logic [ID_W-1:0] id, input logic [63:0] rdata, input logic err);
        checkOutput("resp_valid", {63'd0, resp_valid}, 64'd1);
        checkOutput("resp_id", {60'd0, resp_id}, {60'd0, id});
        checkOutput("resp_rdata", resp_rdata, rdata);
        checkOutput("resp_err", {63'd0, resp_err}, {63'd0, err});
        checkOutput("req_ready_in_resp", {63'd0, req_ready}, 64'd0);
        nextCycle();
        checkOutput("resp_one_cycle", {63'd0, resp_valid}, 64'd0);
        checkOutput("req_ready_after", {63'd0, req_ready}, 64'd1);
    endtask

    // One complete transaction; delay0 is the AR or AW ready delay, delay1 the
    // W ready delay, delay2 the R or B valid delay.
    task automatic runTxn(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                          input logic [63:0] wdata, input logic [ID_W-1:0] id,
                          input int delay0, input int delay1, input int delay2,
                          input logic [1:0] resp, input logic [63:0] slaveData);
        int         nBytes;
        int         off;
        bit         mis;
        logic [7:0] expStrb;
        logic [63:0] expWdata;
        logic [63:0] expRdata;
        bit         awSeen;
        bit         wSeen;
        int         c;

        nBytes = 1 << size;
        off    = int'(addr[2:0]);
        mis    = (addr % nBytes) != 0;
        expStrb  = '0;
        expWdata = '0;
        expRdata = '0;
        for (int j = 0; j < 8; j++) begin
            if (j >= off) begin
                expWdata[8*j +: 8] = wdata[8*(j-off) +: 8];
            end
            if (j >= off && j < off + nBytes) begin
                expStrb[j] = 1'b1;
            end
        end
        for (int i = 0; i < nBytes; i++) begin
            if (off + i < 8) begin
                expRdata[8*i +: 8] = slaveData[8*(off+i) +: 8];
            end
        end

        applyStimulus(wr, addr, size, wdata, id);

        if (mis) begin
            checkOutput("mis_no_ar", {63'd0, ar_valid}, 64'd0);
            checkOutput("mis_no_aw", {63'd0, aw_valid}, 64'd0);
            checkOutput("mis_no_w", {63'd0, w_valid}, 64'd0);
            checkOutput("mis_no_resp_yet", {63'd0, resp_valid}, 64'd0);
            nextCycle();
            checkOutput("mis_no_ar2", {63'd0, ar_valid}, 64'd0);
            checkResponse(id, 64'd0, 1'b1);
        end else if (!wr) begin
            for (int d = 0; d <= delay0; d++) begin
                ar_ready = (d == delay0);
                checkOutput("ar_valid", {63'd0, ar_valid}, 64'd1);
                checkOutput("ar_addr", {32'd0, ar_addr}, {32'd0, addr});
                checkOutput("ar_id", {60'd0, ar_id}, {60'd0, id});
                checkOutput("ar_size", {61'd0, ar_size}, 64'(size));
                checkOutput("ar_len", {56'd0, ar_len}, 64'd0);
                checkOutput("ar_burst", {62'd0, ar_burst}, 64'd1);
                checkOutput("r_ready_early", {63'd0, r_ready}, 64'd0);
                nextCycle();
            end
            ar_ready = 1'b0;
            for (int d = 0; d <= delay2; d++) begin
                r_valid = (d == delay2);
                r_data  = (d == delay2) ? slaveData : {$urandom, $urandom};
                r_resp  = resp;
                r_last  = 1'b1;
                r_id    = id;
                checkOutput("r_ready", {63'd0, r_ready}, 64'd1);
                checkOutput("ar_dropped", {63'd0, ar_valid}, 64'd0);
                nextCycle();
            end
            r_valid = 1'b0;
            checkResponse(id, expRdata, resp != 2'b00);
        end else begin
            awSeen = 1'b0;
            wSeen  = 1'b0;
            c      = 0;
            while (!(awSeen && wSeen)) begin
                if (c > 40) begin
                    checkOutput("aw_w_timeout", 64'd0, 64'd1);
                    break;
                end
                aw_ready = !awSeen && (c >= delay0);
                w_ready  = !wSeen && (c >= delay1);
                checkOutput("aw_valid", {63'd0, aw_valid}, {63'd0, !awSeen});
                checkOutput("w_valid", {63'd0, w_valid}, {63'd0, !wSeen});
                checkOutput("b_ready_early", {63'd0, b_ready}, 64'd0);
                if (!awSeen) begin
                    checkOutput("aw_addr", {32'd0, aw_addr}, {32'd0, addr});
                    checkOutput("aw_id", {60'd0, aw_id}, {60'd0, id});
                    checkOutput("aw_size", {61'd0, aw_size}, 64'(size));
                    checkOutput("aw_len", {56'd0, aw_len}, 64'd0);
                    checkOutput("aw_burst", {62'd0, aw_burst}, 64'd1);
                end
                if (!wSeen) begin
                    checkOutput("w_data", w_data, expWdata);
                    checkOutput("w_strb", {56'd0, w_strb}, {56'd0, expStrb});
                    checkOutput("w_last", {63'd0, w_last}, 64'd1);
                end
                @(posedge clock);
                if (aw_ready) awSeen = 1'b1;
                if (w_ready) wSeen = 1'b1;
                @(negedge clock);
                c++;
            end
            aw_ready = 1'b0;
            w_ready  = 1'b0;
            for (int d = 0; d <= delay2; d++) begin
                b_valid = (d == delay2);
                b_resp  = resp;
                b_id    = id;
                checkOutput("b_ready", {63'd0, b_ready}, 64'd1);
                checkOutput("aw_dropped", {63'd0, aw_valid}, 64'd0);
                checkOutput("w_dropped", {63'd0, w_valid}, 64'd0);
                nextCycle();
            end
            b_valid = 1'b0;
            checkResponse(id, 64'd0, resp != 2'b00);
        end
    endtask

    task automatic checkQuiet(input string phase);
        checkOutput({phase, "_req_ready"}, {63'd0, req_ready}, 64'd1);
        checkOutput({phase, "_ar_valid"}, {63'd0, ar_valid}, 64'd0);
        checkOutput({phase, "_r_ready"}, {63'd0, r_ready}, 64'd0);
        checkOutput({phase, "_aw_valid"}, {63'd0, aw_valid}, 64'd0);
        checkOutput({phase, "_w_valid"}, {63'd0, w_valid}, 64'd0);
        checkOutput({phase, "_b_ready"}, {63'd0, b_ready}, 64'd0);
        checkOutput({phase, "_resp_valid"}, {63'd0, resp_valid}, 64'd0);
        checkOutput({phase, "_resp_err"}, {63'd0, resp_err}, 64'd0);
    endtask

    initial begin
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [1:0]  resp;

        reset     = 1'b1;
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_addr  = '0;
        req_size  = '0;
        req_wdata = '0;
        req_id    = '0;
        aw_ready  = 1'b0;
        w_ready   = 1'b0;
        b_valid   = 1'b0;
        b_resp    = '0;
        b_id      = '0;
        ar_ready  = 1'b0;
        r_valid   = 1'b0;
        r_data    = '0;
        r_resp    = '0;
        r_last    = 1'b0;
        r_id      = '0;

        @(negedge clock);
        nextCycle();
        checkQuiet("reset");
        checkOutput("reset_resp_rdata", resp_rdata, 64'd0);
        checkOutput("reset_resp_id", {60'd0, resp_id}, 64'd0);
        checkOutput("reset_ar_addr", {32'd0, ar_addr}, 64'd0);
        checkOutput("reset_aw_addr", {32'd0, aw_addr}, 64'd0);
        checkOutput("reset_w_data", w_data, 64'd0);
        checkOutput("reset_w_strb", {56'd0, w_strb}, 64'd0);
        checkOutput("reset_ar_len", {56'd0, ar_len}, 64'd0);
        checkOutput("reset_aw_len", {56'd0, aw_len}, 64'd0);
        checkOutput("reset_ar_burst", {62'd0, ar_burst}, 64'd1);
        checkOutput("reset_aw_burst", {62'd0, aw_burst}, 64'd1);
        checkOutput("reset_w_last", {63'd0, w_last}, 64'd1);
        reset = 1'b0;
        nextCycle();

        $display("[TB] directed cases");
        runTxn(1'b0, 32'h8000_0008, 2'b11, 64'd0, 4'h3, 0, 0, 0, 2'b00, 64'h1122_3344_5566_7788);
        runTxn(1'b1, 32'h8000_0005, 2'b00, 64'hAB, 4'h5, 0, 0, 0, 2'b00, 64'd0);
        runTxn(1'b1, 32'h8000_0004, 2'b10, 64'hDEAD_BEEF, 4'h7, 3, 0, 1, 2'b00, 64'd0);
        runTxn(1'b0, 32'h8000_0006, 2'b01, 64'd0, 4'h9, 1, 0, 2, 2'b10, 64'hBEEF_0000_0000_0000);
        runTxn(1'b0, 32'h8000_0002, 2'b10, 64'd0, 4'hA, 0, 0, 0, 2'b00, 64'd0);
        runTxn(1'b1, 32'h8000_0010, 2'b11, 64'h0123_4567_89AB_CDEF, 4'hC, 0, 2, 0, 2'b11, 64'd0);

        $display("[TB] reset while waiting for B");
        applyStimulus(1'b1, 32'h8000_0000, 2'b10, 64'h5555_AAAA, 4'h2);
        aw_ready = 1'b1;
        w_ready  = 1'b1;
        nextCycle();
        aw_ready = 1'b0;
        w_ready  = 1'b0;
        checkOutput("abort_b_ready", {63'd0, b_ready}, 64'd1);
        nextCycle();
        checkOutput("abort_b_ready_held", {63'd0, b_ready}, 64'd1);
        reset = 1'b1;
        nextCycle();
        checkQuiet("abort");
        reset = 1'b0;
        runTxn(1'b0, 32'h8000_0020, 2'b10, 64'd0, 4'h4, 0, 0, 0, 2'b00, 64'hCAFE_F00D_1234_5678);

        $display("[TB] random cases");
        for (int n = 0; n < 60; n++) begin
            wr   = 1'($urandom);
            size = 2'($urandom);
            addr = 32'h8000_0000 | 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) begin
                addr = addr & ~((32'd1 << size) - 32'd1);
            end
            resp = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            runTxn(wr, addr, size, {$urandom, $urandom}, ID_W'($urandom),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   resp, {$urandom, $urandom});
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
